// File: rtl/td4_cpu_system_if.sv
// Program-memory load port for td4_cpu_system.
// The loader drives the master side and the CPU takes the slave side.
interface td4_prog_if;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_wdata;

  modport master (output prog_we, output prog_addr, output prog_wdata);
  modport slave  (input  prog_we, input  prog_addr, input  prog_wdata);
endinterface

// File: rtl/td4_cpu_system.sv
// 4-bit single-cycle accumulator CPU (TD4-class ISA) with a 16x8 program memory.
// The instruction at PC is read combinationally and executed at each rising edge.
module td4_cpu_system (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       btn,
  output logic [3:0]       led,
  td4_prog_if.slave        prog
);

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned INSTR_W = 8;
  localparam int unsigned DEPTH   = 16;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              c_q, c_d;

  logic [INSTR_W-1:0] instr;
  logic [3:0]         opcode;
  logic [DATA_W-1:0]  im;
  logic [DATA_W:0]    sum_a;
  logic [DATA_W:0]    sum_b;

  // Program memory is never reset; writes are honoured during reset as well.
  always_ff @(posedge clk) begin
    if (prog.prog_we) begin
      mem_q[prog.prog_addr] <= prog.prog_wdata;
    end
  end

  assign instr  = mem_q[pc_q];
  assign opcode = instr[7:4];
  assign im     = instr[3:0];
  assign sum_a  = {1'b0, a_q} + {1'b0, im};
  assign sum_b  = {1'b0, b_q} + {1'b0, im};

  // Decode/execute; carry is cleared by every non-ADD instruction.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    pc_d  = pc_q + ADDR_W'(1);
    c_d   = 1'b0;
    case (opcode)
      OP_ADD_A:  {c_d, a_d} = sum_a;
      OP_ADD_B:  {c_d, b_d} = sum_b;
      OP_MOV_AI: a_d = im;
      OP_MOV_BI: b_d = im;
      OP_MOV_AB: a_d = b_q;
      OP_MOV_BA: b_d = a_q;
      OP_IN_A:   a_d = btn;
      OP_IN_B:   b_d = btn;
      OP_OUT_B:  out_d = b_q;
      OP_OUT_I:  out_d = im;
      OP_JMP:    pc_d = im;
      OP_JNC:    if (!c_q) pc_d = im;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      pc_q  <= '0;
      c_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      pc_q  <= pc_d;
      c_q   <= c_d;
    end
  end

  assign led = out_q;

endmodule

// File: tb/tb_td4_cpu_system.sv
// Self-checking bench for td4_cpu_system: table of programs plus hand-written
// sequences for reset, wrap, mid-run reset and write-at-PC.
module tb_td4_cpu_system;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] led;

  td4_prog_if prog_bus ();

  td4_cpu_system dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .led   (led),
    .prog  (prog_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] prog;   // word 0 in the top byte
    logic [3:0]  btn;
    logic [7:0]  cycles;
    logic [3:0]  led;
    logic [3:0]  pc;
    logic        c;
  } vec_t;

  typedef struct packed {
    logic [3:0] led;
    logic [3:0] pc;
    logic       c;
  } exp_t;

  localparam int NVEC = 19;
  vec_t  vecs [NVEC];
  exp_t  sb_q [$];
  string tag_q [$];
  int    tests  = 0;
  int    failed = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [3:0] l,
                          input logic [3:0] p, input logic c);
    exp_t e;
    e.led = l;
    e.pc  = p;
    e.c   = c;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string tag;
    tests++;
    if (sb_q.size() == 0) begin
      failed++;
      $display("FAIL scoreboard: empty queue at compare");
      return;
    end
    e   = sb_q.pop_front();
    tag = tag_q.pop_front();
    if (led !== e.led || dut.pc_q !== e.pc || dut.c_q !== e.c) begin
      failed++;
      $display("FAIL %s: got led=%h pc=%h c=%b, want led=%h pc=%h c=%b",
               tag, led, dut.pc_q, dut.c_q, e.led, e.pc, e.c);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] act,
                        input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Loads all 16 words while reset is held low, then releases reset.
  task automatic load_prog(input logic [63:0] words);
    reset = 1'b0;
    prog_bus.prog_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_bus.prog_addr  = 4'(i);
      prog_bus.prog_wdata = (i < 8) ? words[63-8*i -: 8] : 8'h00;
      step();
    end
    prog_bus.prog_we = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    btn = 4'h0;
    prog_bus.prog_we    = 1'b0;
    prog_bus.prog_addr  = 4'h0;
    prog_bus.prog_wdata = 8'h00;

    //            program                  btn   cyc   led   pc    c
    vecs[0]  = '{64'hB5_3A_06_E5_B1_BF_F6_00, 4'h0, 8'd1,  4'h5, 4'h1, 1'b0};
    vecs[1]  = '{64'hB5_3A_06_E5_B1_BF_F6_00, 4'h0, 8'd3,  4'h5, 4'h3, 1'b1};
    vecs[2]  = '{64'hB5_3A_06_E5_B1_BF_F6_00, 4'h0, 8'd4,  4'h5, 4'h4, 1'b0};
    vecs[3]  = '{64'hB5_3A_06_E5_B1_BF_F6_00, 4'h0, 8'd5,  4'h1, 4'h5, 1'b0};
    vecs[4]  = '{64'hB5_3A_06_E5_B1_BF_F6_00, 4'h0, 8'd10, 4'hF, 4'h6, 1'b0};
    vecs[5]  = '{64'h20_40_90_00_00_00_00_00, 4'h9, 8'd3,  4'h9, 4'h3, 1'b0};
    vecs[6]  = '{64'h33_E8_00_00_00_00_00_00, 4'h0, 8'd2,  4'h0, 4'h8, 1'b0};
    vecs[7]  = '{64'h01_E7_00_00_00_00_00_00, 4'h0, 8'd2,  4'h0, 4'h7, 1'b0};
    vecs[8]  = '{64'h70_51_90_F1_00_00_00_00, 4'h0, 8'd46, 4'hF, 4'h1, 1'b0};
    vecs[9]  = '{64'h70_51_90_F1_00_00_00_00, 4'h0, 8'd47, 4'hF, 4'h2, 1'b1};
    vecs[10] = '{64'h70_51_90_F1_00_00_00_00, 4'h0, 8'd48, 4'h0, 4'h3, 1'b0};
    vecs[11] = '{64'h7C_14_05_40_60_55_90_A3, 4'h6, 8'd7,  4'hB, 4'h7, 1'b0};
    vecs[12] = '{64'h7C_14_05_40_60_55_90_A3, 4'h6, 8'd3,  4'h0, 4'h3, 1'b1};
    vecs[13] = '{64'hC1_D2_8F_A4_B3_00_00_00, 4'h0, 8'd5,  4'h3, 4'h5, 1'b0};
    vecs[14] = '{64'h0F_01_C0_00_00_00_00_00, 4'h0, 8'd2,  4'h0, 4'h2, 1'b1};
    vecs[15] = '{64'h0F_01_C0_00_00_00_00_00, 4'h0, 8'd3,  4'h0, 4'h3, 1'b0};
    vecs[16] = '{64'h3F_01_F7_00_00_00_00_00, 4'h0, 8'd3,  4'h0, 4'h7, 1'b0};
    vecs[17] = '{64'hFF_00_00_00_00_00_00_00, 4'h0, 8'd2,  4'h0, 4'h0, 1'b0};
    vecs[18] = '{64'h0F_01_E9_00_00_00_00_00, 4'h0, 8'd3,  4'h0, 4'h3, 1'b0};

    // Reset with the all-zero program, then PC counts and wraps.
    load_prog(64'h0);
    push_exp("reset_state", 4'h0, 4'h0, 1'b0);
    pop_check();
    for (int k = 1; k <= 17; k++) begin
      push_exp($sformatf("nop_count_%0d", k), 4'h0, 4'(k), 1'b0);
      step();
      pop_check();
    end

    for (int v = 0; v < NVEC; v++) begin
      load_prog(vecs[v].prog);
      btn = vecs[v].btn;
      push_exp($sformatf("vec%0d", v), vecs[v].led, vecs[v].pc, vecs[v].c);
      repeat (int'(vecs[v].cycles)) step();
      pop_check();
    end

    // Mid-run reset while led=7: state clears, memory survives.
    load_prog(64'hB7_39_75_F3_00_00_00_00);
    push_exp("pre_reset", 4'h7, 4'h3, 1'b0);
    repeat (4) step();
    pop_check();
    check4("pre_reset_a", dut.a_q, 4'h9);
    check4("pre_reset_b", dut.b_q, 4'h5);
    reset = 1'b0;
    push_exp("mid_reset", 4'h0, 4'h0, 1'b0);
    step();
    pop_check();
    check4("mid_reset_a", dut.a_q, 4'h0);
    check4("mid_reset_b", dut.b_q, 4'h0);
    reset = 1'b1;
    push_exp("restart", 4'h7, 4'h1, 1'b0);
    step();
    pop_check();

    // Overwrite the word at PC: old JMP 0 runs, new OUT 14 runs next cycle.
    load_prog(64'hF0_00_00_00_00_00_00_00);
    prog_bus.prog_we    = 1'b1;
    prog_bus.prog_addr  = 4'h0;
    prog_bus.prog_wdata = 8'hBE;
    push_exp("write_at_pc_old", 4'h0, 4'h0, 1'b0);
    step();
    pop_check();
    prog_bus.prog_we = 1'b0;
    push_exp("write_at_pc_new", 4'hE, 4'h1, 1'b0);
    step();
    pop_check();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
